// File: rtl/ps2_key_decoder_pkg.sv
// PS/2 keyboard decoder shared definitions: prefix bytes, set-2 letter
// scan codes, receiver states and the letter lookup helper.
package ps2_key_decoder_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam int         KEY_COUNT = 26;

    // Index i holds the make code of letter 'A'+i.
    localparam logic [7:0] LETTER_CODE [KEY_COUNT] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
        8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
        8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
        8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
    };

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    typedef struct packed {
        logic       hit;
        logic [4:0] idx;
    } key_hit_t;

    function automatic key_hit_t letter_lookup(input logic [7:0] code);
        key_hit_t r;
        r.hit = 1'b0;
        r.idx = '0;
        for (int i = 0; i < KEY_COUNT; i++) begin
            if (code == LETTER_CODE[i]) begin
                r.hit = 1'b1;
                r.idx = 5'(i);
            end
        end
        return r;
    endfunction

    // PS/2 uses odd parity over the 8 data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] d,
                                           input logic       p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_key_decoder_rx.sv
// PS/2 frame receiver: pin synchroniser, falling-edge detect, frame FSM,
// mid-frame timeout and parity/stop checking.
// Ports: clk, reset (async, active-high), ps2_clk/ps2_data (raw pins),
// byte_valid (1-cycle pulse), byte_data (held), frame_err (1-cycle pulse).
// Build option: define PS2_PARITY_CHECK_EN to reject frames with bad parity.
module ps2_key_decoder_rx
    import ps2_key_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   fall;
    logic                   din;

    rx_state_e   state, state_n;
    logic [2:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  shreg, shreg_n;
    logic        par_bit, par_n;
    logic [TW-1:0] to_cnt, to_cnt_n;
    logic        bv_n;
    logic [7:0]  bd_n;
    logic        fe_n;
    logic        frame_ok;

    // Idle bus is high, so the synchroniser resets to 1 to avoid a
    // phantom falling edge right after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign din  = data_sync[SYNC_STAGES-1];

`ifdef PS2_PARITY_CHECK_EN
    assign frame_ok = din & odd_parity_ok(shreg, par_bit);
`else
    assign frame_ok = din;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RX_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            to_cnt     <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            par_bit    <= par_n;
            to_cnt     <= to_cnt_n;
            byte_valid <= bv_n;
            byte_data  <= bd_n;
            frame_err  <= fe_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        par_n     = par_bit;
        to_cnt_n  = '0;
        bv_n      = 1'b0;
        bd_n      = byte_data;
        fe_n      = 1'b0;

        unique case (state)
            RX_IDLE: begin
                if (fall && !din) begin
                    state_n   = RX_DATA;
                    bit_cnt_n = '0;
                end
            end
            RX_DATA: begin
                if (fall) begin
                    shreg_n   = {din, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = RX_PARITY;
                    end
                end
            end
            RX_PARITY: begin
                if (fall) begin
                    par_n   = din;
                    state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (fall) begin
                    state_n = RX_IDLE;
                    if (frame_ok) begin
                        bv_n = 1'b1;
                        bd_n = shreg;
                    end else begin
                        fe_n = 1'b1;
                    end
                end
            end
            default: state_n = RX_IDLE;
        endcase

        // Mid-frame watchdog: any edge restarts it, expiry drops the frame.
        if (state != RX_IDLE && !fall) begin
            if (to_cnt == TO_LAST) begin
                state_n  = RX_IDLE;
                fe_n     = 1'b1;
                to_cnt_n = '0;
            end else begin
                to_cnt_n = to_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 keyboard decoder: tracks make/break of letters A-Z into a
// level-held key_status vector and re-exports every accepted byte.
// Ports: clk, reset (async, active-high), ps2_clk/ps2_data (raw pins),
// key_status[25:0] (bit i = 'A'+i held), byte_valid, byte_data, frame_err.
// Build option: define PS2_PARITY_CHECK_EN to reject frames with bad parity.
module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ps2_clk,
    input  logic                 ps2_data,
    output logic [KEY_COUNT-1:0] key_status,
    output logic                 byte_valid,
    output logic [7:0]           byte_data,
    output logic                 frame_err
);

    logic     brk;
    logic     ext;
    key_hit_t hit;

    ps2_key_decoder_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    assign hit = letter_lookup(byte_data);

    // Prefix bytes only arm flags; the next ordinary byte consumes them.
    // Extended codes are never letters, so they are dropped whole.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_status <= '0;
            brk        <= 1'b0;
            ext        <= 1'b0;
        end else if (byte_valid) begin
            unique case (1'b1)
                (byte_data == PS2_BREAK): brk <= 1'b1;
                (byte_data == PS2_EXT):   ext <= 1'b1;
                default: begin
                    if (!ext && hit.hit) begin
                        key_status[hit.idx] <= ~brk;
                    end
                    brk <= 1'b0;
                    ext <= 1'b0;
                end
            endcase
        end
    end

endmodule
